// File: rtl/x87_memstore_queue.sv
// x87 store-result queue: buffers FPU store pulses with their address and
// replays them as one or two 32-bit writes on a req/done memory port.
module x87_memstore_queue #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    input  logic [1:0]  i_in_size,
    input  logic [63:0] i_in_data64,
    input  logic [31:0] i_in_addr,
    output logic        o_in_ready,
    output logic        o_wr_req,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [2:0]  o_wr_length,
    input  logic        i_wr_done,
    output logic        o_empty,
    output logic        o_overflow,
    output logic        o_size_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [1:0]  r_mem_size [DEPTH];
    logic [63:0] r_mem_data [DEPTH];
    logic [31:0] r_mem_addr [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nx;

    logic [1:0]  r_cur_size;
    logic [63:0] r_cur_data;
    logic [31:0] r_cur_addr;
    logic [1:0]  w_cur_size;
    logic [63:0] w_cur_data;
    logic [31:0] w_cur_addr;

    logic        w_push;
    logic        w_pop;
    logic        w_done;
    logic        w_req_nx;
    logic [31:0] w_addr_nx;
    logic [31:0] w_data_nx;
    logic [2:0]  w_len_nx;

    // Full check uses the registered count, so a same-cycle pop never frees a slot.
    assign w_push = i_in_valid && (i_in_size != 2'd3) && (r_count != FULL);
    assign w_done = o_wr_req && i_wr_done;

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop      = 1'b1;
                    w_state_nx = WR_LO;
                end
            end
            WR_LO, WR_HI: begin
                if (w_done) begin
                    if (r_state == WR_LO && r_cur_size == 2'd2) begin
                        w_state_nx = WR_HI;
                    end else if (r_count != '0) begin
                        w_pop      = 1'b1;
                        w_state_nx = WR_LO;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        w_cur_size = w_pop ? r_mem_size[r_rptr] : r_cur_size;
        w_cur_data = w_pop ? r_mem_data[r_rptr] : r_cur_data;
        w_cur_addr = w_pop ? r_mem_addr[r_rptr] : r_cur_addr;
        w_count_nx = r_count + CW'(w_push) - CW'(w_pop);

        // Outputs are registered, so they are derived from next state.
        w_req_nx  = 1'b0;
        w_addr_nx = '0;
        w_data_nx = '0;
        w_len_nx  = '0;
        unique case (w_state_nx)
            WR_LO: begin
                w_req_nx  = 1'b1;
                w_addr_nx = w_cur_addr;
                if (w_cur_size == 2'd0) begin
                    w_data_nx = {16'h0, w_cur_data[15:0]};
                    w_len_nx  = 3'd2;
                end else begin
                    w_data_nx = w_cur_data[31:0];
                    w_len_nx  = 3'd4;
                end
            end
            WR_HI: begin
                w_req_nx  = 1'b1;
                w_addr_nx = w_cur_addr + 32'd4;
                w_data_nx = w_cur_data[63:32];
                w_len_nx  = 3'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_cur_size  <= '0;
            r_cur_data  <= '0;
            r_cur_addr  <= '0;
            o_wr_req    <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_wr_length <= '0;
            o_in_ready  <= 1'b1;
            o_empty     <= 1'b1;
            o_overflow  <= 1'b0;
            o_size_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_count     <= w_count_nx;
            r_cur_size  <= w_cur_size;
            r_cur_data  <= w_cur_data;
            r_cur_addr  <= w_cur_addr;
            o_wr_req    <= w_req_nx;
            o_wr_addr   <= w_addr_nx;
            o_wr_data   <= w_data_nx;
            o_wr_length <= w_len_nx;
            o_in_ready  <= (w_count_nx != FULL);
            o_empty     <= (w_count_nx == '0) && (w_state_nx == IDLE);
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (i_in_valid && i_in_size == 2'd3) o_size_err <= 1'b1;
            if (i_in_valid && i_in_size != 2'd3 && r_count == FULL) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_size[r_wptr] <= i_in_size;
            r_mem_data[r_wptr] <= i_in_data64;
            r_mem_addr[r_wptr] <= i_in_addr;
        end
    end

endmodule

// File: tb/tb_x87_memstore_queue.sv
// Bench for x87_memstore_queue: store-level queue model checked every
// cycle, plus literal write sequences for each directed scenario.
module tb_x87_memstore_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_in_valid;
    logic [1:0]  i_in_size;
    logic [63:0] i_in_data64;
    logic [31:0] i_in_addr;
    logic        i_wr_done;
    logic        o_in_ready;
    logic        o_wr_req;
    logic [31:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic [2:0]  o_wr_length;
    logic        o_empty;
    logic        o_overflow;
    logic        o_size_err;

    x87_memstore_queue #(.DEPTH(DEPTH)) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_in_valid(i_in_valid),
        .i_in_size(i_in_size),
        .i_in_data64(i_in_data64),
        .i_in_addr(i_in_addr),
        .o_in_ready(o_in_ready),
        .o_wr_req(o_wr_req),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_wr_length(o_wr_length),
        .i_wr_done(i_wr_done),
        .o_empty(o_empty),
        .o_overflow(o_overflow),
        .o_size_err(o_size_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  l;
    } wr_t;

    typedef struct {
        logic [1:0]  s;
        logic [63:0] d;
        logic [31:0] a;
    } st_t;

    int n_vec = 0;
    int n_err = 0;

    st_t pend[$];
    wr_t cur[$];
    wr_t wlog[$];
    bit  m_ovf = 0;
    bit  m_serr = 0;
    bit  m_on = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Store-level model: pending stores plus the dword writes still owed
    // for the store currently being written.
    always @(posedge clk) begin
        st_t h;
        st_t ns;
        bit  acc;
        if (i_rst) begin
            pend.delete();
            cur.delete();
            m_ovf = 0;
            m_serr = 0;
            m_on = 1;
        end else if (m_on) begin
            acc = 0;
            ns = '{s: i_in_size, d: i_in_data64, a: i_in_addr};
            if (i_in_valid) begin
                if (i_in_size == 2'd3) m_serr = 1;
                else if (pend.size() == DEPTH) m_ovf = 1;
                else acc = 1;
            end
            if (cur.size() > 0 && i_wr_done) void'(cur.pop_front());
            if (cur.size() == 0 && pend.size() > 0) begin
                h = pend.pop_front();
                if (h.s == 2'd0) begin
                    cur.push_back('{a: h.a, d: {16'h0, h.d[15:0]}, l: 3'd2});
                end else begin
                    cur.push_back('{a: h.a, d: h.d[31:0], l: 3'd4});
                    if (h.s == 2'd2)
                        cur.push_back('{a: h.a + 32'd4, d: h.d[63:32], l: 3'd4});
                end
            end
            if (acc) pend.push_back(ns);
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("wr_req", o_wr_req, cur.size() > 0);
            if (cur.size() > 0) begin
                chk("wr_addr", o_wr_addr, cur[0].a);
                chk("wr_data", o_wr_data, cur[0].d);
                chk("wr_length", o_wr_length, cur[0].l);
            end
            chk("empty", o_empty, pend.size() == 0 && cur.size() == 0);
            chk("in_ready", o_in_ready, pend.size() != DEPTH);
            chk("overflow", o_overflow, m_ovf);
            chk("size_err", o_size_err, m_serr);
            if (o_wr_req && i_wr_done)
                wlog.push_back('{a: o_wr_addr, d: o_wr_data, l: o_wr_length});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] s, input logic [63:0] d,
                         input logic [31:0] a);
        i_in_valid = 1'b1;
        i_in_size = s;
        i_in_data64 = d;
        i_in_addr = a;
        tick(1);
        i_in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 80; i++) begin
            if (o_empty) break;
            tick(1);
        end
        chk("drain", o_empty, 1'b1);
    endtask

    task automatic exp_wr(input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] l);
        if (idx >= wlog.size()) begin
            chk("log_missing", 64'(wlog.size()), 64'(idx + 1));
        end else begin
            chk("log_addr", wlog[idx].a, a);
            chk("log_data", wlog[idx].d, d);
            chk("log_len", wlog[idx].l, l);
        end
    endtask

    initial begin
        logic [31:0] pat;
        pat = 32'b1011_0010_0110_1001_1100_0101_1010_0111;
        i_rst = 1'b1;
        i_in_valid = 1'b0;
        i_in_size = '0;
        i_in_data64 = '0;
        i_in_addr = '0;
        i_wr_done = 1'b0;
        tick(2);
        i_rst = 1'b0;
        chk("rst_req", o_wr_req, 1'b0);
        chk("rst_addr", o_wr_addr, 32'h0);
        chk("rst_data", o_wr_data, 32'h0);
        chk("rst_len", o_wr_length, 3'd0);
        chk("rst_ready", o_in_ready, 1'b1);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_serr", o_size_err, 1'b0);

        // 64-bit store, done tied high
        wlog.delete();
        i_wr_done = 1'b1;
        store(2'd2, 64'h1122_3344_5566_7788, 32'h0000_1000);
        wait_empty();
        chk("t1_n", 64'(wlog.size()), 64'd2);
        exp_wr(0, 32'h0000_1000, 32'h5566_7788, 3'd4);
        exp_wr(1, 32'h0000_1004, 32'h1122_3344, 3'd4);

        // 16-bit and 32-bit stores, upper data bits must be ignored
        wlog.delete();
        store(2'd0, 64'h1234_5678_9ABC_ABCD, 32'h0000_2002);
        wait_empty();
        store(2'd1, 64'hCAFE_CAFE_DEAD_BEEF, 32'h0000_3000);
        wait_empty();
        chk("t2_n", 64'(wlog.size()), 64'd2);
        exp_wr(0, 32'h0000_2002, 32'h0000_ABCD, 3'd2);
        exp_wr(1, 32'h0000_3000, 32'hDEAD_BEEF, 3'd4);

        // address wrap on the high dword
        wlog.delete();
        store(2'd2, 64'hAAAA_BBBB_CCCC_DDDD, 32'hFFFF_FFFC);
        wait_empty();
        chk("t3_n", 64'(wlog.size()), 64'd2);
        exp_wr(0, 32'hFFFF_FFFC, 32'hCCCC_DDDD, 3'd4);
        exp_wr(1, 32'h0000_0000, 32'hAAAA_BBBB, 3'd4);

        // overflow: one entry in flight, then five pulses into a 4-deep FIFO
        wlog.delete();
        i_wr_done = 1'b0;
        store(2'd1, 64'h0000_0000_0000_00AA, 32'h0000_4000);
        tick(1);
        chk("t4_busy", o_wr_req, 1'b1);
        for (int i = 0; i < 5; i++) begin
            i_in_valid = 1'b1;
            i_in_size = 2'd1;
            i_in_data64 = 64'(i);
            i_in_addr = 32'h0000_4100 + 32'(4 * i);
            tick(1);
        end
        i_in_valid = 1'b0;
        chk("t4_ovf", o_overflow, 1'b1);
        chk("t4_ready", o_in_ready, 1'b0);
        i_wr_done = 1'b1;
        wait_empty();
        chk("t4_n", 64'(wlog.size()), 64'd5);
        exp_wr(0, 32'h0000_4000, 32'h0000_00AA, 3'd4);
        for (int i = 0; i < 4; i++)
            exp_wr(i + 1, 32'h0000_4100 + 32'(4 * i), 32'(i), 3'd4);

        // back-pressure with an illegal-size pulse inside the burst
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        wlog.delete();
        for (int k = 0; k < 40; k++) begin
            i_in_valid = (k < 4);
            case (k)
                0: begin
                    i_in_size = 2'd2;
                    i_in_data64 = 64'h0102_0304_0506_0708;
                    i_in_addr = 32'h0000_5000;
                end
                1: begin
                    i_in_size = 2'd3;
                    i_in_data64 = 64'hEEEE_EEEE_EEEE_EEEE;
                    i_in_addr = 32'h0000_6000;
                end
                2: begin
                    i_in_size = 2'd0;
                    i_in_data64 = 64'hFFFF_FFFF_FFFF_1234;
                    i_in_addr = 32'h0000_5100;
                end
                3: begin
                    i_in_size = 2'd1;
                    i_in_data64 = 64'h9999_9999_8765_4321;
                    i_in_addr = 32'h0000_5200;
                end
                default: ;
            endcase
            i_wr_done = pat[k % 32];
            tick(1);
        end
        i_in_valid = 1'b0;
        i_wr_done = 1'b1;
        wait_empty();
        chk("t5_serr", o_size_err, 1'b1);
        chk("t5_n", 64'(wlog.size()), 64'd4);
        exp_wr(0, 32'h0000_5000, 32'h0506_0708, 3'd4);
        exp_wr(1, 32'h0000_5004, 32'h0102_0304, 3'd4);
        exp_wr(2, 32'h0000_5100, 32'h0000_1234, 3'd2);
        exp_wr(3, 32'h0000_5200, 32'h8765_4321, 3'd4);

        // reset during WR_HI with two entries queued
        wlog.delete();
        i_wr_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_in_valid = 1'b1;
            i_in_size = (i == 0) ? 2'd2 : 2'd1;
            i_in_data64 = 64'h7777_6666_5555_4444 + 64'(i);
            i_in_addr = 32'h0000_7000 + 32'(256 * i);
            tick(1);
        end
        i_in_valid = 1'b0;
        i_wr_done = 1'b1;
        tick(1);
        i_wr_done = 1'b0;
        tick(1);
        chk("t6_hi_addr", o_wr_addr, 32'h0000_7004);
        i_rst = 1'b1;
        tick(1);
        chk("t6_req", o_wr_req, 1'b0);
        chk("t6_empty", o_empty, 1'b1);
        i_rst = 1'b0;
        i_wr_done = 1'b1;
        tick(10);
        chk("t6_req_after", o_wr_req, 1'b0);
        chk("t6_n", 64'(wlog.size()), 64'd1);
        exp_wr(0, 32'h0000_7000, 32'h5555_4444, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/x87_memstore_queue.md
# x87_memstore_queue

Downstream consumer of the x87 execution top's store outputs (`memstore_valid`/`memstore_size`/`memstore_data64`). It buffers FPU store results together with their linear address in a small FIFO. It then issues them to the ao486 data-write path as one or two 32-bit write transactions under a req/done handshake. This decouples single-cycle FPU store pulses, which cannot be back-pressured, from a multi-cycle memory write port.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: one-cycle store pulse (driven by `memstore_valid`).
- `in_size` in 2: store size. 0 = 16-bit, 1 = 32-bit, 2 = 64-bit, 3 = illegal.
- `in_data64` in 64: store data, little-endian, LSB-aligned.
- `in_addr` in 32: linear byte address of the store.
- `in_ready` out 1: FIFO not full (registered; informational only).
- `wr_req` out 1: write request; held high until `wr_done`.
- `wr_addr` out 32: write address.
- `wr_data` out 32: write data.
- `wr_length` out 3: byte count, 2 or 4.
- `wr_done` in 1: memory accepted the current write this cycle.
- `empty` out 1: FIFO empty and no write in flight.
- `overflow` out 1: sticky; an enqueue was dropped because the FIFO was full.
- `size_err` out 1: sticky; an enqueue with `in_size==3` was discarded.

## Operation
Reset (`rst` high at a clock edge):
- Pointers and count clear; the FSM goes to IDLE.
- Outputs: `wr_req`=0, `wr_addr`=0, `wr_data`=0, `wr_length`=0, `in_ready`=1, `empty`=1, `overflow`=0, `size_err`=0.
- Reset mid-transaction abandons the transaction and all queued entries with no further `wr_req`.

Enqueue, on a cycle with `in_valid`=1:
- `in_size`==3: no entry is written; `size_err` is set.
- Otherwise, if count==DEPTH (registered count, before any same-cycle pop): the entry is dropped and `overflow` is set.
- Otherwise: {size, data, addr} is written at the write pointer, the pointer increments modulo DEPTH, and count increments.

FSM states are IDLE, WR_LO and WR_HI.
- IDLE, count>0: pop the head entry into the working registers and go to WR_LO.
- WR_LO drives `wr_req`=1 and `wr_addr`=addr.
  - Size 0: `wr_data`={16'h0, data[15:0]}, `wr_length`=2.
  - Size 1 or 2: `wr_data`=data[31:0], `wr_length`=4.
- WR_LO on `wr_done`:
  - Size 2: go to WR_HI.
  - Otherwise: go to IDLE, or straight back to WR_LO with the next entry popped if count>0 (back-to-back).
- WR_HI drives `wr_addr`=addr+4 (32-bit wrap, carry discarded), `wr_data`=data[63:32], `wr_length`=4.
  - On `wr_done`: same exit rule as WR_LO.
- Pop decrements count on the cycle the entry is loaded into the working registers. Simultaneous push and pop leaves count unchanged.
- Entries issue in strict FIFO order. The low dword is always written before the high dword.

Status outputs:
- `empty` = (count==0) and state==IDLE.
- `in_ready` = (count!=DEPTH).
- `overflow` and `size_err` clear only on reset.

## Timing
- All outputs are registered.
- Enqueue at edge N:
  - With the FIFO empty and the FSM idle, the entry is popped at N+1 and `wr_req`=1 is visible after edge N+1.
  - Minimum latency from `in_valid` to `wr_req` is 2 cycles.
- `wr_done` is sampled only while `wr_req`=1.
  - `wr_done` in the same cycle `wr_req` first rises is legal; it completes the write at that edge.
  - `wr_done` while `wr_req`=0 is ignored.
- After `wr_done` at edge M:
  - Next `wr_req` (WR_HI or the next entry) is high after edge M with the new address and data. There are no idle cycles between back-to-back writes.
  - Otherwise `wr_req`=0 after edge M.
- `wr_addr`, `wr_data` and `wr_length` are stable while `wr_req`=1 and `wr_done`=0.
- Full boundary: the FIFO holds exactly DEPTH entries. The (DEPTH+1)-th pulse with no intervening pop is dropped.
- Throughput: one 32-bit write per cycle when `wr_done` is tied high.

## Test plan
- Reset then idle: after `rst`, all outputs are at their reset values. After one 64-bit store (addr 0x0000_1000, data 0x1122_3344_5566_7788) with `wr_done` tied high, the writes are (0x1000, 0x5566_7788, len 4) then (0x1004, 0x1122_3344, len 4), and `empty` returns to 1.
- 16-bit and 32-bit stores:
  - size 0, data 0xABCD at 0x2002 -> single write (0x2002, 0x0000_ABCD, len 2).
  - size 1, data 0xDEAD_BEEF -> single write, len 4.
- Address wrap: 64-bit store at 0xFFFF_FFFC -> second write at 0x0000_0000.
- Overflow: DEPTH=4, `wr_done`=0, five consecutive pulses.
  - Expect four entries and `overflow`=1 with `in_ready`=0.
  - Releasing `wr_done` issues exactly the first four, in order.
- Back-pressure and back-to-back: random `wr_done` stalls with a 3-entry burst.
  - Outputs stay stable while stalled.
  - There are no gaps between writes when `wr_done` is high.
  - `size_err` sets on an `in_size`=3 pulse and no write is issued for it.
- Reset mid-operation: assert `rst` during WR_HI with 2 entries queued. `wr_req` is 0 the next cycle, `empty`=1, and no stale writes follow.
